// File: rtl/sample_feeder.sv
// sample_feeder: sample FIFO feeding a filter controller through a sample/result handshake.
// Ports:
//   clk          sole clock, rising edge
//   GlobalReset  asynchronous active-high reset
//   din, din_wr  sample enqueue data and strobe
//   full, empty  FIFO occupancy flags
//   srdyi        one-cycle "sample ready" strobe, sample valid while high
//   sample       registered sample presented to the filter
//   srdyo,result filter "result ready" strobe and its data
//   dout         last captured result, dout_valid pulses on each update
//   busy         transaction in flight (ISSUE or WAIT)
//   ovf_err      sticky: write attempted while full
//   to_err       sticky: no result within TIMEOUT+1 WAIT cycles
//   err_clr      synchronous clear of both sticky flags (a same-cycle set wins)
module sample_feeder #(
    parameter int DATA_W  = 16,
    parameter int RES_W   = 36,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              GlobalReset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_wr,
    output logic              full,
    output logic              empty,
    output logic              srdyi,
    output logic [DATA_W-1:0] sample,
    input  logic              srdyo,
    input  logic [RES_W-1:0]  result,
    output logic [RES_W-1:0]  dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              ovf_err,
    output logic              to_err,
    input  logic              err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TW-1:0]     timer_q;
    logic              push, pop, timeout, ovf_d, to_d;
    logic              srdyi_q, dout_valid_q, ovf_q, to_q;
    logic [DATA_W-1:0] sample_q;
    logic [RES_W-1:0]  dout_q;

    // full/empty come from the registered count, so a write while full is
    // dropped even when ISSUE pops in the same cycle
    assign full       = count_q == CW'(DEPTH);
    assign empty      = count_q == '0;
    assign busy       = state_q != IDLE;
    assign srdyi      = srdyi_q;
    assign sample     = sample_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign ovf_err    = ovf_q;
    assign to_err     = to_q;

    always_comb begin
        push    = din_wr && !full;
        pop     = state_q == ISSUE;
        timeout = state_q == WAIT && !srdyo && timer_q == TW'(TIMEOUT);
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        ovf_d   = (din_wr && full) || (ovf_q && !err_clr);
        to_d    = timeout || (to_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr_q] <= din;
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
        end
    end

    // srdyi and sample are loaded on the IDLE->ISSUE edge so they are
    // registered outputs aligned with the ISSUE cycle; the pop follows it
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            srdyi_q      <= 1'b0;
            sample_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            srdyi_q      <= 1'b0;
            dout_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q  <= ISSUE;
                        srdyi_q  <= 1'b1;
                        sample_q <= mem[rptr_q];
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    timer_q <= '0;
                end
                WAIT: begin
                    if (srdyo) begin
                        dout_q       <= result;
                        dout_valid_q <= 1'b1;
                        state_q      <= IDLE;
                    end else if (timer_q == TW'(TIMEOUT)) begin
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_feeder.sv
// tb_sample_feeder: randomized and directed checks of sample_feeder against a transaction-level model.
module tb_sample_feeder;
    localparam int DW = 16;
    localparam int RW = 36;
    localparam int DEPTH = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          GlobalReset = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_wr = 1'b0;
    logic          srdyo = 1'b0;
    logic [RW-1:0] result = '0;
    logic          err_clr = 1'b0;
    logic          full, empty, srdyi, dout_valid, busy, ovf_err, to_err;
    logic [DW-1:0] sample;
    logic [RW-1:0] dout;

    always #5 clk = ~clk;

    sample_feeder #(.DATA_W(DW), .RES_W(RW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .GlobalReset(GlobalReset), .din(din), .din_wr(din_wr),
        .full(full), .empty(empty), .srdyi(srdyi), .sample(sample),
        .srdyo(srdyo), .result(result), .dout(dout), .dout_valid(dout_valid),
        .busy(busy), .ovf_err(ovf_err), .to_err(to_err), .err_clr(err_clr)
    );

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;

    // model: queue of stored samples; age = -1 when no transaction,
    // 0 on the issue cycle, k>=1 on the k-th cycle spent awaiting a result
    logic [DW-1:0] mq[$];
    int            age;
    logic [DW-1:0] m_sample;
    logic [RW-1:0] m_dout;
    logic          m_dv, m_ovf, m_to, prev_srdyi;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        age = -1;
        m_sample = '0;
        m_dout = '0;
        m_dv = 1'b0;
        m_ovf = 1'b0;
        m_to = 1'b0;
        prev_srdyi = 1'b0;
    endtask

    task automatic model_step();
        bit was_full = (mq.size() == DEPTH);
        bit issuing = (age == 0);
        bit to_set = 1'b0;
        m_dv = 1'b0;
        if (age < 0) begin
            if (mq.size() > 0) begin
                age = 0;
                m_sample = mq[0];
            end
        end else if (age == 0) begin
            age = 1;
        end else if (srdyo) begin
            m_dout = result;
            m_dv = 1'b1;
            age = -1;
        end else if (age - 1 == TO) begin
            to_set = 1'b1;
            age = -1;
        end else begin
            age++;
        end
        if (issuing) void'(mq.pop_front());
        if (din_wr && !was_full) mq.push_back(din);
        m_ovf = (din_wr && was_full) || (m_ovf && !err_clr);
        m_to = to_set || (m_to && !err_clr);
    endtask

    task automatic compare();
        check("srdyi", 64'(srdyi), 64'(age == 0));
        check("busy", 64'(busy), 64'(age >= 0));
        check("empty", 64'(empty), 64'(mq.size() == 0));
        check("full", 64'(full), 64'(mq.size() == DEPTH));
        check("sample", 64'(sample), 64'(m_sample));
        check("dout", 64'(dout), 64'(m_dout));
        check("dout_valid", 64'(dout_valid), 64'(m_dv));
        check("ovf_err", 64'(ovf_err), 64'(m_ovf));
        check("to_err", 64'(to_err), 64'(m_to));
        check("srdyi_back_to_back", 64'(prev_srdyi & srdyi), 64'd0);
        prev_srdyi = srdyi;
    endtask

    task automatic cyc(input logic wr, input logic [DW-1:0] d, input logic so,
                       input logic [RW-1:0] r, input logic clr);
        din_wr = wr;
        din = d;
        srdyo = so;
        result = r;
        err_clr = clr;
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // reset is raised at a falling edge and checked before any rising edge
    task automatic do_reset();
        GlobalReset = 1'b1;
        din_wr = 1'b0;
        srdyo = 1'b0;
        err_clr = 1'b0;
        #1;
        check("rst_srdyi", 64'(srdyi), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_ovf", 64'(ovf_err), 64'd0);
        check("rst_to", 64'(to_err), 64'd0);
        check("rst_sample", 64'(sample), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        GlobalReset = 1'b0;
        cyc_n = 0;
    endtask

    initial begin
        logic [DW-1:0] sent[$];
        logic [DW-1:0] d;
        int got, nsent, last_issue, so_at;
        @(negedge clk);
        do_reset();

        // single transaction latency
        cyc(1'b1, 16'h0011, 1'b0, '0, 1'b0);
        idle(1);
        check("t1_srdyi", 64'(srdyi), 64'd1);
        check("t1_sample", 64'(sample), 64'h0011);
        check("t1_busy", 64'(busy), 64'd1);
        idle(3);
        cyc(1'b0, '0, 1'b1, 36'h123, 1'b0);
        check("t1_dout", 64'(dout), 64'h123);
        check("t1_dout_valid", 64'(dout_valid), 64'd1);

        // overflow: fill, then a dropped 0xBEEF that must never be issued
        do_reset();
        for (int i = 0; i < 20 && mq.size() < DEPTH; i++) cyc(1'b1, DW'(16'h0100 + i), 1'b0, '0, 1'b0);
        check("t2_full", 64'(full), 64'd1);
        cyc(1'b1, 16'hBEEF, 1'b0, '0, 1'b0);
        check("t2_ovf", 64'(ovf_err), 64'd1);
        check("t2_full_after", 64'(full), 64'd1);
        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, '0, 1'($urandom_range(0, 1)), RW'($urandom()), 1'b0);
            check("t2_beef_issued", 64'(srdyi && sample == 16'hBEEF), 64'd0);
        end

        // timeout after 16 WAIT cycles, then clear
        do_reset();
        cyc(1'b1, 16'hA5A5, 1'b0, '0, 1'b0);
        idle(17);
        check("t3_to_early", 64'(to_err), 64'd0);
        check("t3_busy_early", 64'(busy), 64'd1);
        idle(1);
        check("t3_to_set", 64'(to_err), 64'd1);
        check("t3_idle", 64'(busy), 64'd0);
        check("t3_dout_kept", 64'(dout), 64'd0);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        check("t3_to_clr", 64'(to_err), 64'd0);

        // result exactly on the last timer value wins over timeout
        do_reset();
        cyc(1'b1, 16'h5A5A, 1'b0, '0, 1'b0);
        idle(17);
        cyc(1'b0, '0, 1'b1, 36'hABCDE12, 1'b0);
        check("t4_dout", 64'(dout), 64'hABCDE12);
        check("t4_dout_valid", 64'(dout_valid), 64'd1);
        check("t4_to", 64'(to_err), 64'd0);

        // reset during WAIT with samples queued
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, DW'(16'h0200 + i), 1'b0, '0, 1'b0);
        check("t5_busy", 64'(busy), 64'd1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, 1'b1, 36'h777, 1'b0);
            check("t5_no_dout_valid", 64'(dout_valid), 64'd0);
            check("t5_no_srdyi", 64'(srdyi), 64'd0);
        end

        // stream of 20 samples, result two cycles after each srdyi
        do_reset();
        got = 0; nsent = 0; last_issue = -1; so_at = -1;
        for (int i = 0; i < 300 && got < 20; i++) begin
            if (srdyi) begin
                check("t6_order", 64'(sample), 64'(sent[got]));
                if (last_issue >= 0) check("t6_spacing", 64'(cyc_n - last_issue), 64'd4);
                got++;
                last_issue = cyc_n;
                so_at = cyc_n + 2;
            end
            if (nsent < 20 && mq.size() < DEPTH) begin
                d = DW'($urandom());
                sent.push_back(d);
                nsent++;
                cyc(1'b1, d, cyc_n == so_at, RW'($urandom()), 1'b0);
            end else begin
                cyc(1'b0, '0, cyc_n == so_at, RW'($urandom()), 1'b0);
            end
        end
        check("t6_count", 64'(got), 64'd20);

        // random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc(1'($urandom_range(0, 99) < 60), DW'($urandom()), 1'($urandom_range(0, 99) < 25),
                {4'($urandom()), 32'($urandom())}, 1'($urandom_range(0, 99) < 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
